// File: rtl/div_seq_pkg.sv
// Shared constants for the sequential signed divider: widths, state codes and the divide-by-zero quotient.
package div_seq_pkg;
  localparam int unsigned DIV_W    = 32;
  localparam int unsigned DIV_ITER = 32;
  localparam int unsigned CNT_W    = 5;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;

  localparam logic [DIV_W-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_ITER - 1);
endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between the control unit (master) and the divider (slave).
interface div_seq_if;
  import div_seq_pkg::*;

  logic             start;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/Add.sv
// 32-bit carry-lookahead adder: 4-bit groups with group generate/propagate feeding the group carries.
module Add
  import div_seq_pkg::*;
(
  input  logic [DIV_W-1:0] a,
  input  logic [DIV_W-1:0] b,
  input  logic             c_in,
  output logic [DIV_W-1:0] sum_c,
  output logic             c_out_c
);
  localparam int unsigned GRP  = 4;
  localparam int unsigned NGRP = DIV_W / GRP;

  logic [DIV_W-1:0] g;
  logic [DIV_W-1:0] p;
  logic [DIV_W:0]   c;
  logic [NGRP:0]    cg;
  logic             gg;
  logic             gp;

  // Group carries are resolved first; bit carries inside a group derive from the group carry-in.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    cg    = '0;
    gg    = 1'b0;
    gp    = 1'b1;
    cg[0] = c_in;
    for (int k = 0; k < NGRP; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int j = 0; j < GRP; j++) begin
        gg = g[k*GRP+j] | (p[k*GRP+j] & gg);
        gp = gp & p[k*GRP+j];
      end
      cg[k+1]  = gg | (gp & cg[k]);
      c[k*GRP] = cg[k];
      for (int j = 0; j < GRP - 1; j++) begin
        c[k*GRP+j+1] = g[k*GRP+j] | (p[k*GRP+j] & c[k*GRP+j]);
      end
    end
    c[DIV_W] = cg[NGRP];
  end

  assign sum_c   = p ^ c[DIV_W-1:0];
  assign c_out_c = c[DIV_W];
endmodule

// File: rtl/div_neg.sv
// Two's-complement negation (invert plus one) through an Add instance.
module div_neg
  import div_seq_pkg::*;
(
  input  logic [DIV_W-1:0] x,
  output logic [DIV_W-1:0] neg_c
);
  logic unused_co;

  Add u_add (
    .a       (~x),
    .b       ('0),
    .c_in    (1'b1),
    .sum_c   (neg_c),
    .c_out_c (unused_co)
  );
endmodule

// File: rtl/div_seq.sv
// Multi-cycle 32-bit signed restoring divider: one quotient bit per cycle, sign fix-up in a final cycle.
module div_seq
  import div_seq_pkg::*;
(
  input  logic      clk,
  input  logic      clr_n,
  div_seq_if.slave  bus
);
  logic [1:0]       state,     state_nx;
  logic [CNT_W-1:0] cnt,       cnt_nx;
  logic [DIV_W-1:0] q,         q_nx;
  logic [DIV_W:0]   r,         r_nx;
  logic [DIV_W-1:0] d,         d_nx;
  logic             sign_q,    sign_q_nx;
  logic             sign_r,    sign_r_nx;
  logic             busy,      busy_nx;
  logic             done,      done_nx;
  logic [DIV_W-1:0] quot,      quot_nx;
  logic [DIV_W-1:0] rem,       rem_nx;
  logic             div_zero,  div_zero_nx;

  logic [DIV_W:0]   t;
  logic [DIV_W-1:0] diff;
  logic             trial_co;
  logic             ok;
  logic [DIV_W-1:0] neg_a_in, neg_a;
  logic [DIV_W-1:0] neg_b_in, neg_b;
  logic             unused_r_msb;

  // Trial subtraction T[31:0] - D; a set T[32] means T already exceeds D.
  assign t = {r[DIV_W-1:0], q[DIV_W-1]};

  Add u_trial (
    .a       (t[DIV_W-1:0]),
    .b       (~d),
    .c_in    (1'b1),
    .sum_c   (diff),
    .c_out_c (trial_co)
  );

  assign ok = t[DIV_W] | trial_co;

  // R stays below D, so its top bit only ever holds zero after an iteration.
  assign unused_r_msb = r[DIV_W];

  // Negators take the raw operands in IDLE (magnitudes) and Q/R in FIX (sign restore).
  assign neg_a_in = (state == DIV_IDLE) ? bus.dividend : q;
  assign neg_b_in = (state == DIV_IDLE) ? bus.divisor  : r[DIV_W-1:0];

  div_neg u_neg_a (.x(neg_a_in), .neg_c(neg_a));
  div_neg u_neg_b (.x(neg_b_in), .neg_c(neg_b));

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    q_nx        = q;
    r_nx        = r;
    d_nx        = d;
    sign_q_nx   = sign_q;
    sign_r_nx   = sign_r;
    busy_nx     = busy;
    done_nx     = 1'b0;
    quot_nx     = quot;
    rem_nx      = rem;
    div_zero_nx = div_zero;
    case (state)
      DIV_IDLE: begin
        if (bus.start) begin
          q_nx        = bus.dividend[DIV_W-1] ? neg_a : bus.dividend;
          d_nx        = bus.divisor[DIV_W-1]  ? neg_b : bus.divisor;
          r_nx        = '0;
          sign_q_nx   = bus.dividend[DIV_W-1] ^ bus.divisor[DIV_W-1];
          sign_r_nx   = bus.dividend[DIV_W-1];
          cnt_nx      = '0;
          busy_nx     = 1'b1;
          div_zero_nx = 1'b0;
          state_nx    = (bus.divisor == '0) ? DIV_FIX : DIV_CALC;
        end
      end
      DIV_CALC: begin
        r_nx   = ok ? {1'b0, diff} : t;
        q_nx   = {q[DIV_W-2:0], ok};
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == DIV_LAST) begin
          state_nx = DIV_FIX;
        end
      end
      DIV_FIX: begin
        // A zero D can only come from a zero divisor; Q then still holds |dividend|.
        if (d == '0) begin
          quot_nx     = DIV_ZERO_Q;
          rem_nx      = sign_r ? neg_a : q;
          div_zero_nx = 1'b1;
        end else begin
          quot_nx     = sign_q ? neg_a : q;
          rem_nx      = sign_r ? neg_b : r[DIV_W-1:0];
          div_zero_nx = 1'b0;
        end
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = DIV_IDLE;
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      q        <= '0;
      r        <= '0;
      d        <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      q        <= q_nx;
      r        <= r_nx;
      d        <= d_nx;
      sign_q   <= sign_q_nx;
      sign_r   <= sign_r_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      quot     <= quot_nx;
      rem      <= rem_nx;
      div_zero <= div_zero_nx;
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.quotient  = quot;
  assign bus.remainder = rem;
  assign bus.div_zero  = div_zero;
endmodule

// File: tb/tb_div_seq.sv
// Directed and random checks of div_seq against a plain-arithmetic signed division model.
module tb_div_seq;
  logic clk   = 1'b0;
  logic clr_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  div_seq_if bus ();

  div_seq u_dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating signed division, remainder follows the dividend sign.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eq, output logic [31:0] er, output logic edz);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      eq  = 32'hFFFF_FFFF;
      er  = a;
      edz = 1'b1;
    end else begin
      eq  = 32'(sa / sb);
      er  = 32'(sa % sb);
      edz = 1'b0;
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input int n, input int lat);
    logic [31:0] eq, er;
    logic        edz;
    model(a, b, eq, er, edz);
    chk({tag, ".lat"}, 64'(n), 64'(lat));
    chk({tag, ".q"},   64'(bus.quotient),  64'(eq));
    chk({tag, ".r"},   64'(bus.remainder), 64'(er));
    chk({tag, ".dz"},  64'(bus.div_zero),  64'(edz));
    chk({tag, ".busy_done"}, 64'(bus.busy), 64'(0));
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that raised done.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b);
    int n;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, ".busy"},   64'(bus.busy),     64'(1));
    chk({tag, ".dz_clr"}, 64'(bus.div_zero), 64'(0));
    wait_done(n);
    check_result(tag, a, b, n, (b == 32'd0) ? 1 : 33);
  endtask

  initial begin
    int          n;
    int          seen;
    logic [31:0] ra, rb;
    int unsigned m;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1 clr_n = 1'b0;
    #20;
    chk("rst.busy", 64'(bus.busy),      64'(0));
    chk("rst.done", 64'(bus.done),      64'(0));
    chk("rst.q",    64'(bus.quotient),  64'(0));
    chk("rst.r",    64'(bus.remainder), 64'(0));
    chk("rst.dz",   64'(bus.div_zero),  64'(0));
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    run("d100_7", 32'd100, 32'd7);
    chk("d100_7.q_lit", 64'(bus.quotient),  64'(14));
    chk("d100_7.r_lit", 64'(bus.remainder), 64'(2));
    @(posedge clk);
    #1;
    chk("d100_7.done_1cyc", 64'(bus.done),     64'(0));
    chk("d100_7.hold",      64'(bus.quotient), 64'(14));

    run("dm100_7", 32'hFFFF_FF9C, 32'd7);
    chk("dm100_7.q_lit", 64'(bus.quotient),  64'(32'hFFFF_FFF2));
    chk("dm100_7.r_lit", 64'(bus.remainder), 64'(32'hFFFF_FFFE));
    run("d100_m7", 32'd100, 32'hFFFF_FFF9);
    run("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf.q_lit", 64'(bus.quotient), 64'(32'h8000_0000));
    run("m1_1", 32'hFFFF_FFFF, 32'd1);
    run("min_min", 32'h8000_0000, 32'h8000_0000);
    run("small_big", 32'd3, 32'h7FFF_FFFF);
    run("z55", 32'd55, 32'd0);
    chk("z55.r_lit", 64'(bus.remainder), 64'(55));
    run("zneg", 32'h8000_0000, 32'd0);
    run("after_z", 32'd9, 32'd3);

    // start re-pulsed mid-divide with other operands must be ignored
    bus.start    = 1'b1;
    bus.dividend = 32'd1234567;
    bus.divisor  = 32'hFFFF_FFF3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
    end
    bus.start    = 1'b1;
    bus.dividend = 32'd77;
    bus.divisor  = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n);
    check_result("ignore", 32'd1234567, 32'hFFFF_FFF3, n + 10, 33);

    // start held high: second divide accepted in the done cycle
    bus.start    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'hFFFF_FFDF;
    @(posedge clk);
    #1;
    bus.dividend = 32'hFFFF_EC78;
    bus.divisor  = 32'd7;
    wait_done(n);
    check_result("b2b_a", 32'd1000, 32'hFFFF_FFDF, n, 33);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b.busy", 64'(bus.busy), 64'(1));
    chk("b2b.done", 64'(bus.done), 64'(0));
    wait_done(n);
    check_result("b2b_b", 32'hFFFF_EC78, 32'd7, n, 33);

    // reset in the middle of a divide
    bus.start    = 1'b1;
    bus.dividend = 32'd123456;
    bus.divisor  = 32'd789;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      #1;
    end
    #2 clr_n = 1'b0;
    #1;
    chk("mrst.busy", 64'(bus.busy),      64'(0));
    chk("mrst.done", 64'(bus.done),      64'(0));
    chk("mrst.q",    64'(bus.quotient),  64'(0));
    chk("mrst.r",    64'(bus.remainder), 64'(0));
    chk("mrst.dz",   64'(bus.div_zero),  64'(0));
    @(negedge clk);
    clr_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
    chk("mrst.no_done", 64'(seen), 64'(0));
    run("post_rst", 32'd9, 32'd3);

    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      if (k % 3 == 0) ra = 32'($urandom_range(0, 1000));
      m = $urandom_range(0, 7);
      if (m == 0) begin
        rb = 32'd0;
      end else if (m < 4) begin
        rb = 32'($urandom_range(1, 50));
        if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
      end else begin
        rb = $urandom;
      end
      run("rand", ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
